// File: rtl/seg_scan_controller_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Optional feature macro used by this slice: LEADING_ZERO_BLANK_EN.
package seg_scan_controller_pkg;

    typedef enum logic {
        ST_DEAD  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_OFF    = 7'b1111111;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    // Digit k>0 is worth showing only if some nibble at or above k is non-zero.
    function automatic logic [NUM_DIGITS-1:0] lz_visible(input logic [15:0] v);
        logic [NUM_DIGITS-1:0] vis;
        vis[0] = 1'b1;
        vis[1] = |v[15:4];
        vis[2] = |v[15:8];
        vis[3] = |v[15:12];
        return vis;
    endfunction

endpackage

// File: rtl/seg_scan_controller_hex_to_7segment.sv
// Hex nibble to common-anode 7-segment decoder; seg = {a,b,c,d,e,f,g}, active-low.
module hex_to_7segment (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        unique case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed 4-digit scan controller with per-digit dead time and tear-free frame commit.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_controller
    import seg_scan_controller_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        dp,
    output logic [1:0]  digit_sel,
    output logic        frame_done
);

    localparam int unsigned CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         sel_q, sel_d;

    logic [15:0]        shadow_val_q, shadow_val_d;
    logic [3:0]         shadow_dp_q, shadow_dp_d;
    logic               pending_q, pending_d;
    logic [15:0]        committed_val_q, committed_val_d;
    logic [3:0]         committed_dp_q, committed_dp_d;

    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic               frame_done_q, frame_done_d;

    logic               commit;
    logic [3:0]         cur_nibble;
    logic [6:0]         dec_seg;
    logic [3:0]         vis;

    hex_to_7segment u_dec (
        .hex (cur_nibble),
        .seg (dec_seg)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        sel_d   = sel_q;
        if (state_q == ST_DEAD) begin
            if (cnt_q == DEAD_LAST) begin
                state_d = ST_DRIVE;
                cnt_d   = '0;
            end
        end else begin
            if (cnt_q == DRIVE_LAST) begin
                state_d = ST_DEAD;
                cnt_d   = '0;
                sel_d   = sel_q + 2'd1;
            end
        end
    end

    // Commit on the last DRIVE cycle of digit 3; a load in that same cycle bypasses the shadow.
    always_comb begin
        commit = (state_q == ST_DRIVE) && (sel_q == 2'd3) && (cnt_q == DRIVE_LAST);

        shadow_val_d    = shadow_val_q;
        shadow_dp_d     = shadow_dp_q;
        pending_d       = pending_q;
        committed_val_d = committed_val_q;
        committed_dp_d  = committed_dp_q;

        if (load) begin
            shadow_val_d = value;
            shadow_dp_d  = dp_in;
            pending_d    = 1'b1;
        end

        if (commit) begin
            pending_d = 1'b0;
            if (load) begin
                committed_val_d = value;
                committed_dp_d  = dp_in;
            end else if (pending_q) begin
                committed_val_d = shadow_val_q;
                committed_dp_d  = shadow_dp_q;
            end
        end
    end

    always_comb begin
        cur_nibble = committed_val_q[{sel_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        vis = lz_visible(committed_val_q);
`else
        vis = '1;
`endif

        // Segments settle during DEAD so they are stable before the anode turns on.
        seg_d = (state_q == ST_DEAD) ? dec_seg : seg_q;

        an_d = AN_OFF;
        if ((state_d == ST_DRIVE) && digit_en[sel_d] && vis[sel_d]) begin
            an_d[sel_d] = 1'b0;
        end

        dp_d         = ~((state_d == ST_DRIVE) && committed_dp_q[sel_d]);
        frame_done_d = (state_d == ST_DRIVE) && (sel_d == 2'd3) && (cnt_d == DRIVE_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_DEAD;
            cnt_q           <= '0;
            sel_q           <= '0;
            shadow_val_q    <= '0;
            shadow_dp_q     <= '0;
            pending_q       <= 1'b0;
            committed_val_q <= '0;
            committed_dp_q  <= '0;
            an_q            <= AN_OFF;
            seg_q           <= SEG_OFF;
            dp_q            <= 1'b1;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            sel_q           <= sel_d;
            shadow_val_q    <= shadow_val_d;
            shadow_dp_q     <= shadow_dp_d;
            pending_q       <= pending_d;
            committed_val_q <= committed_val_d;
            committed_dp_q  <= committed_dp_d;
            an_q            <= an_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign an                    = an_q;
    assign {a, b, c, d, e, f, g} = seg_q;
    assign dp                    = dp_q;
    assign digit_sel             = sel_q;
    assign frame_done            = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller (REFRESH_DIV=4, DEAD_CYCLES=2, 24-cycle frame).
// Build with LEADING_ZERO_BLANK_EN defined to exercise leading-zero blanking expectations.
module tb_seg_scan_controller;

    localparam int unsigned RD    = 4;
    localparam int unsigned DC    = 2;
    localparam int unsigned SLOT  = RD + DC;
    localparam int unsigned FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  an;
    logic        a, b, c, d, e, f, g, dp;
    logic [1:0]  digit_sel;
    logic        frame_done;

    int unsigned cyc;
    int unsigned vectors = 0;
    int unsigned errors  = 0;

    typedef struct {
        int unsigned t;
        logic [3:0]  an;
        logic        chk_seg;
        logic [6:0]  seg;
        logic        dp;
        logic [1:0]  sel;
        logic        fd;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_val;
    logic [3:0]  m_dp;

    seg_scan_controller #(
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .load       (load),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .an         (an),
        .a          (a),
        .b          (b),
        .c          (c),
        .d          (d),
        .e          (e),
        .f          (f),
        .g          (g),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    initial forever #5 clk = ~clk;

    // Edges since reset release; at a negedge, cyc equals the frame timeline position.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic logic [6:0] ref_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;  default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Expected outputs for timeline positions t0..t1 showing committed value v.
    function automatic void push_span(input int unsigned t0, input int unsigned t1,
                                      input logic [15:0] v, input logic [3:0] dpb,
                                      input logic [3:0] en);
        for (int unsigned t = t0; t <= t1; t++) begin
            exp_t        x;
            int unsigned p, k;
            logic        drive, vis;
            p     = t % FRAME;
            k     = p / SLOT;
            drive = (p % SLOT) >= DC;
`ifdef LEADING_ZERO_BLANK_EN
            vis = (k == 0) || ((v >> (4 * k)) != 16'h0);
`else
            vis = 1'b1;
`endif
            x.t       = t;
            x.an      = (drive && en[k] && vis) ? ~(4'b0001 << k) : 4'hF;
            x.chk_seg = drive;
            x.seg     = drive ? ref_decode(v[4*k +: 4]) : 7'h00;
            x.dp      = !(drive && dpb[k]);
            x.sel     = k[1:0];
            x.fd      = (p == FRAME - 1);
            sb.push_back(x);
        end
    endfunction

    task automatic wait_pos(input int unsigned p);
        do @(negedge clk); while ((cyc % FRAME) != p);
    endtask

    // Drives a one-cycle load; on return cyc is the timeline index of the sampling edge.
    task automatic do_load(input logic [15:0] v, input logic [3:0] dpb);
        value = v;
        dp_in = dpb;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    function automatic int unsigned next_frame(input int unsigned k);
        return ((k + FRAME - 1) / FRAME) * FRAME;
    endfunction

    task automatic test_reset;
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({an, a, b, c, d, e, f, g, dp, digit_sel, frame_done} !== {4'hF, 7'h7F, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got an=%b seg=%b dp=%b sel=%0d fd=%b", an, {a,b,c,d,e,f,g}, dp, digit_sel, frame_done);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_val = '0;
        m_dp  = '0;
        push_span(0, 3, 16'h0000, 4'h0, 4'hF);
        while (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            while (cyc < x.t) @(negedge clk);
            vectors++;
            if ({an, x.chk_seg ? {a,b,c,d,e,f,g} : 7'h00, dp, digit_sel, frame_done} !== {x.an, x.seg, x.dp, x.sel, x.fd}) begin
                errors++;
                $display("FAIL reset_release t=%0d got an=%b seg=%b dp=%b sel=%0d fd=%b exp an=%b seg=%b dp=%b sel=%0d fd=%b",
                         x.t, an, {a,b,c,d,e,f,g}, dp, digit_sel, frame_done, x.an, x.seg, x.dp, x.sel, x.fd);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({an, a, b, c, d, e, f, g} !== {4'hF, 7'h7F}) begin
            errors++;
            $display("FAIL async_reset got an=%b seg=%b exp an=1111 seg=1111111", an, {a,b,c,d,e,f,g});
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_scan_order;
        int unsigned fs;
        digit_en = 4'hF;
        wait_pos(10);
        do_load(16'h4321, 4'h0);
        fs = next_frame(cyc);
        push_span(cyc, fs - 1, m_val, m_dp, digit_en);
        push_span(fs, fs + 2 * FRAME - 1, 16'h4321, 4'h0, digit_en);
        m_val = 16'h4321;
        m_dp  = 4'h0;
        while (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            while (cyc < x.t) @(negedge clk);
            vectors++;
            if ({an, x.chk_seg ? {a,b,c,d,e,f,g} : 7'h00, dp, digit_sel, frame_done} !== {x.an, x.seg, x.dp, x.sel, x.fd}) begin
                errors++;
                $display("FAIL scan_order t=%0d got an=%b seg=%b dp=%b sel=%0d fd=%b exp an=%b seg=%b dp=%b sel=%0d fd=%b",
                         x.t, an, {a,b,c,d,e,f,g}, dp, digit_sel, frame_done, x.an, x.seg, x.dp, x.sel, x.fd);
            end
        end
    endtask

    task automatic test_tear_free;
        int unsigned fs;
        wait_pos(8);
        do_load(16'hAAAA, 4'h0);
        fs = next_frame(cyc);
        push_span(cyc, fs - 1, m_val, m_dp, digit_en);
        push_span(fs, fs + FRAME - 1, 16'hAAAA, 4'h0, digit_en);
        m_val = 16'hAAAA;
        m_dp  = 4'h0;
        while (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            while (cyc < x.t) @(negedge clk);
            vectors++;
            if ({an, x.chk_seg ? {a,b,c,d,e,f,g} : 7'h00, dp, digit_sel, frame_done} !== {x.an, x.seg, x.dp, x.sel, x.fd}) begin
                errors++;
                $display("FAIL tear_free t=%0d got an=%b seg=%b dp=%b sel=%0d fd=%b exp an=%b seg=%b dp=%b sel=%0d fd=%b",
                         x.t, an, {a,b,c,d,e,f,g}, dp, digit_sel, frame_done, x.an, x.seg, x.dp, x.sel, x.fd);
            end
        end
    endtask

    task automatic test_back_to_back;
        int unsigned fs;
        wait_pos(3);
        do_load(16'h1111, 4'hF);
        wait_pos(15);
        do_load(16'h2222, 4'h0);
        fs = next_frame(cyc);
        push_span(cyc, fs - 1, m_val, m_dp, digit_en);
        push_span(fs, fs + FRAME - 1, 16'h2222, 4'h0, digit_en);
        m_val = 16'h2222;
        m_dp  = 4'h0;
        while (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            while (cyc < x.t) @(negedge clk);
            vectors++;
            if ({an, x.chk_seg ? {a,b,c,d,e,f,g} : 7'h00, dp, digit_sel, frame_done} !== {x.an, x.seg, x.dp, x.sel, x.fd}) begin
                errors++;
                $display("FAIL back_to_back t=%0d got an=%b seg=%b dp=%b sel=%0d fd=%b exp an=%b seg=%b dp=%b sel=%0d fd=%b",
                         x.t, an, {a,b,c,d,e,f,g}, dp, digit_sel, frame_done, x.an, x.seg, x.dp, x.sel, x.fd);
            end
        end
    endtask

    task automatic test_load_at_commit;
        wait_pos(4);
        do_load(16'h1234, 4'h2);
        wait_pos(FRAME - 1);
        vectors++;
        if ({frame_done, dut.pending_q} !== 2'b11) begin
            errors++;
            $display("FAIL commit_pos got fd=%b pending=%b exp fd=1 pending=1", frame_done, dut.pending_q);
        end
        do_load(16'h00F0, 4'h0);
        vectors++;
        if (dut.pending_q !== 1'b0) begin
            errors++;
            $display("FAIL commit_pending got pending=%b exp 0", dut.pending_q);
        end
        push_span(cyc, cyc + FRAME - 1, 16'h00F0, 4'h0, digit_en);
        m_val = 16'h00F0;
        m_dp  = 4'h0;
        while (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            while (cyc < x.t) @(negedge clk);
            vectors++;
            if ({an, x.chk_seg ? {a,b,c,d,e,f,g} : 7'h00, dp, digit_sel, frame_done} !== {x.an, x.seg, x.dp, x.sel, x.fd}) begin
                errors++;
                $display("FAIL load_at_commit t=%0d got an=%b seg=%b dp=%b sel=%0d fd=%b exp an=%b seg=%b dp=%b sel=%0d fd=%b",
                         x.t, an, {a,b,c,d,e,f,g}, dp, digit_sel, frame_done, x.an, x.seg, x.dp, x.sel, x.fd);
            end
        end
    endtask

    task automatic test_mask_dp;
        int unsigned fs;
        wait_pos(2);
        digit_en = 4'b0101;
        do_load(16'h8888, 4'b0001);
        fs = next_frame(cyc);
        push_span(cyc, fs - 1, m_val, m_dp, digit_en);
        push_span(fs, fs + FRAME - 1, 16'h8888, 4'b0001, digit_en);
        m_val = 16'h8888;
        m_dp  = 4'b0001;
        while (sb.size() != 0) begin
            exp_t x;
            x = sb.pop_front();
            while (cyc < x.t) @(negedge clk);
            vectors++;
            if ({an, x.chk_seg ? {a,b,c,d,e,f,g} : 7'h00, dp, digit_sel, frame_done} !== {x.an, x.seg, x.dp, x.sel, x.fd}) begin
                errors++;
                $display("FAIL mask_dp t=%0d got an=%b seg=%b dp=%b sel=%0d fd=%b exp an=%b seg=%b dp=%b sel=%0d fd=%b",
                         x.t, an, {a,b,c,d,e,f,g}, dp, digit_sel, frame_done, x.an, x.seg, x.dp, x.sel, x.fd);
            end
        end
        digit_en = 4'hF;
    endtask

    task automatic test_zero_values;
        logic [15:0] vals [2];
        int unsigned fs;
        vals[0] = 16'h0050;
        vals[1] = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            do_load(vals[i], 4'h0);
            fs = next_frame(cyc);
            push_span(cyc, fs - 1, m_val, m_dp, digit_en);
            push_span(fs, fs + FRAME - 1, vals[i], 4'h0, digit_en);
            m_val = vals[i];
            m_dp  = 4'h0;
            while (sb.size() != 0) begin
                exp_t x;
                x = sb.pop_front();
                while (cyc < x.t) @(negedge clk);
                vectors++;
                if ({an, x.chk_seg ? {a,b,c,d,e,f,g} : 7'h00, dp, digit_sel, frame_done} !== {x.an, x.seg, x.dp, x.sel, x.fd}) begin
                    errors++;
                    $display("FAIL zero_values v=%h t=%0d got an=%b seg=%b dp=%b sel=%0d fd=%b exp an=%b seg=%b dp=%b sel=%0d fd=%b",
                             vals[i], x.t, an, {a,b,c,d,e,f,g}, dp, digit_sel, frame_done, x.an, x.seg, x.dp, x.sel, x.fd);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan_order;
        test_tear_free;
        test_back_to_back;
        test_load_at_commit;
        test_mask_dp;
        test_zero_values;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
- Captures a 16-bit value and steps through its four hex nibbles one digit at a time.
- Drives each nibble through the hex_to_7segment decoder, with a dead-time gap between digits to suppress ghosting.
- Sits between the sequence-detector datapath (value source) and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit is driven (DRIVE phase); legal range >= 2.
- DEAD_CYCLES, 16, clk cycles all anodes are off between digits (DEAD phase); legal range >= 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- value  input  16  display value; nibble k is shown on digit k.
- load  input  1  single-cycle strobe that samples value and dp_in.
- dp_in  input  4  decimal-point request per digit, active-high; sampled with load.
- digit_en  input  4  per-digit enable, sampled live; 0 blanks that digit.
- an  output  4  anode drives, active-low.
- a, b, c, d, e, f, g  output  1 each  segment drives, active-low.
- dp  output  1  decimal-point segment, active-low.
- digit_sel  output  2  index of the digit currently being scanned.
- frame_done  output  1  one-cycle pulse at the end of each full 4-digit frame.

Behaviour:
- Reset (asynchronous assert, synchronous release), every output and register:
  - an=4'b1111, {a..g}=7'b1111111, dp=1, digit_sel=0, frame_done=0.
  - shadow=0, committed=0, pending=0, state=DEAD, counter=0.
- State machine has two states, DEAD and DRIVE.
  - DEAD: an=4'b1111. Segment and dp registers are loaded from the decoded nibble committed[4*digit_sel+:4] and committed dp bit. Segments are therefore stable before the anode turns on. After DEAD_CYCLES cycles, go to DRIVE.
  - DRIVE: an[digit_sel]=0 if the digit is enabled, otherwise an stays 4'b1111. After REFRESH_DIV cycles, go to DEAD and set digit_sel to digit_sel+1 mod 4 (3 wraps to 0).
- Slot timing:
  - Each digit slot lasts DEAD_CYCLES+REFRESH_DIV cycles, whether or not the digit is enabled.
  - Frame period = 4*(DEAD_CYCLES+REFRESH_DIV) cycles.
- One counter, clog2(max(REFRESH_DIV, DEAD_CYCLES)) bits wide:
  - reset to 0 on every state change;
  - the terminal count is N-1 for the current phase length N.
- Load capture: load=1 samples value and dp_in into the shadow register and sets pending=1.
- Commit point: the last DRIVE cycle of digit 3, where frame_done=1 for exactly that cycle. There:
  - if pending=1, committed <= shadow and pending is cleared;
  - otherwise committed is held.
- Tear-free rule: committed never changes mid-frame; all four digits of one frame always come from the same value.
- Load arriving in the same cycle as the commit point: the incoming value is committed directly and pending is left at 0 (load wins).
- Back-to-back loads within one frame: the last one wins.
- digit_en affects only the anodes and is not synchronised to frames; a change takes effect on the next clk edge.
- Decimal point: dp is driven low during digit k's DRIVE phase when committed dp bit k = 1.
- Latency: a load takes effect at the next commit point, at most 1 frame plus 1 cycle later.
- Outputs: all are registered, and there is no combinational path from any input to any output.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Digit k (k>0) is blanked (an stays high in its DRIVE phase) when committed nibbles k..3 are all zero.
  - Digit 0 is never blanked this way.
  - This blanking is ANDed with digit_en.
  - Example: committed=16'h0000 shows only digit 0, displaying "0".
- Undefined: only digit_en controls blanking.

Decomposition:
- Shared package / header (seg_scan_pkg.vh) holds:
  - state encodings ST_DEAD=1'b0 and ST_DRIVE=1'b1;
  - localparam NUM_DIGITS=4;
  - the constant SEG_OFF=7'b1111111 and AN_OFF=4'b1111.
- Sub-module: one instance of the existing hex_to_7segment decoder, fed with the selected committed nibble.

Test Plan (REFRESH_DIV=4, DEAD_CYCLES=2, so a frame is 24 cycles):
- Reset: assert reset_n=0 mid-DRIVE -> an=4'b1111 and {a..g}=7'h7F immediately, with no clock needed. After release, the first DRIVE starts on cycle 2 with digit_sel=0.
- Scan order: load value=16'h4321, digit_en=4'hF, then wait for the commit. The next frame must show:
  - an sequence 1110, 1101, 1011, 0111, each low for 4 cycles with 2-cycle all-high gaps;
  - segments 1001111, 0010010, 0000110, 1001100 (digits 1, 2, 3, 4);
  - frame_done pulsing once every 24 cycles.
- Tear-free: load 16'hAAAA while digit 1 is being driven -> the rest of that frame keeps the old nibbles; the following frame shows 0001000 on all four digits.
- Load at commit: load=1 coincident with frame_done=1, value=16'h00F0 -> the next frame shows it, and pending reads 0 afterwards.
- Masking and dp: digit_en=4'b0101, dp_in=4'b0001 loaded ->
  - an[1] and an[3] are never low;
  - dp is low only during digit 0's DRIVE phase.
- LEADING_ZERO_BLANK_EN defined, value=16'h0050 -> digits 0 and 1 are driven; an[2] and an[3] stay high. With value=16'h0000, only digit 0 is driven, displaying 0000001.
